// File: rtl/bullet_pool.sv
// Projectile pool: fixed bullet slots with tick-driven spawn, vertical motion and retire.
// One instance per side; DIR selects travel toward Y_MIN (0) or Y_MAX (1).

module bullet_slot #(
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int SPEED = 4,
  parameter int DIR   = 0,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 step,
  input  logic                 hit,
  input  logic                 spawn,
  input  logic [X_W+Y_W-1:0]   spawn_pos,
  output logic                 active,
  output logic [X_W+Y_W-1:0]   pos,
  output logic                 active_nxt
);
  localparam int P = X_W + Y_W;
  localparam logic [Y_W:0] SPD  = (Y_W+1)'(SPEED);
  localparam logic [Y_W:0] Y_LO = (Y_W+1)'(Y_MIN + SPEED);
  localparam logic [Y_W:0] Y_HI = (Y_W+1)'(Y_MAX);

  logic [P-1:0] pos_nxt;
  logic [Y_W:0] y_ext, y_up, y_down, y_new;
  logic         leave;

  // One extra bit keeps the bound tests free of wraparound.
  always_comb begin
    y_ext  = {1'b0, pos[Y_W-1:0]};
    y_up   = y_ext - SPD;
    y_down = y_ext + SPD;
    leave  = (DIR == 0) ? (y_ext < Y_LO) : (y_down > Y_HI);
    y_new  = (DIR == 0) ? y_up : y_down;
  end

  always_comb begin
    active_nxt = active;
    pos_nxt    = pos;
    if (clear) begin
      active_nxt = 1'b0;
      pos_nxt    = '1;
    end else if (step) begin
      if (active) begin
        if (hit || leave) begin
          active_nxt = 1'b0;
          pos_nxt    = '1;
        end else begin
          pos_nxt = {pos[P-1:Y_W], y_new[Y_W-1:0]};
        end
      end else if (spawn) begin
        active_nxt = 1'b1;
        pos_nxt    = spawn_pos;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      pos    <= '1;
    end else begin
      active <= active_nxt;
      pos    <= pos_nxt;
    end
  end
endmodule

module bullet_pool #(
  parameter int SLOTS    = 15,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int SPEED    = 4,
  parameter int DIR      = 0,
  parameter int COOLDOWN = 11,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479
) (
  input  logic                           i_Clock,
  input  logic                           i_Reset,
  input  logic                           i_Tick,
  input  logic                           i_Clear,
  input  logic                           i_Enable,
  input  logic                           i_Fire,
  input  logic [X_W-1:0]                 i_FireX,
  input  logic [Y_W-1:0]                 i_FireY,
  input  logic [SLOTS-1:0]               i_Hit,
  output logic [SLOTS-1:0]               o_State,
  output logic [SLOTS*(X_W+Y_W)-1:0]     o_Position,
  output logic [5:0]                     o_Count,
  output logic                           o_Ready,
  output logic                           o_FireAck,
  output logic                           o_Drop
);
  localparam int P    = X_W + Y_W;
  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  logic [CD_W-1:0]  cd;
  logic [SLOTS-1:0] active_nxt, free, lowest, spawn_mask;
  logic [5:0]       count_nxt;
  logic             step, cd_zero, fire_ok;

  assign step    = i_Tick & i_Enable & ~i_Clear;
  assign cd_zero = (cd == '0);
  assign free    = ~o_State;
  // Isolate lowest set bit of the pre-tick free mask.
  assign lowest     = free & (~free + SLOTS'(1));
  assign fire_ok    = i_Fire & cd_zero & (|free);
  assign spawn_mask = fire_ok ? lowest : '0;
  assign o_Ready    = cd_zero & (|free);

  genvar k;
  generate
    for (k = 0; k < SLOTS; k++) begin : g_slot
      bullet_slot #(
        .X_W(X_W), .Y_W(Y_W), .SPEED(SPEED), .DIR(DIR), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
      ) u_slot (
        .clk        (i_Clock),
        .rst_n      (i_Reset),
        .clear      (i_Clear),
        .step       (step),
        .hit        (i_Hit[k]),
        .spawn      (spawn_mask[k]),
        .spawn_pos  ({i_FireX, i_FireY}),
        .active     (o_State[k]),
        .pos        (o_Position[k*P +: P]),
        .active_nxt (active_nxt[k])
      );
    end
  endgenerate

  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < SLOTS; i++) count_nxt = count_nxt + {5'b0, active_nxt[i]};
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      cd        <= '0;
      o_Count   <= '0;
      o_FireAck <= 1'b0;
      o_Drop    <= 1'b0;
    end else begin
      o_Count <= count_nxt;
      if (i_Clear) begin
        cd        <= '0;
        o_FireAck <= 1'b0;
        o_Drop    <= 1'b0;
      end else if (step) begin
        o_FireAck <= fire_ok;
        o_Drop    <= i_Fire & ~fire_ok;
        if (fire_ok)       cd <= CD_LOAD;
        else if (!cd_zero) cd <= cd - 1'b1;
      end else begin
        o_FireAck <= 1'b0;
        o_Drop    <= 1'b0;
      end
    end
  end
endmodule
